// File: rtl/xram_slot_arbiter_pkg.sv
// Shared widths, phase numbering and requester ids for the XRAM aux-slot arbiter.
package xram_pkg;

  localparam int XRAM_AW = 19;
  localparam int XRAM_DW = 8;

  localparam logic [1:0] PH_SLOT0 = 2'd0;
  localparam logic [1:0] PH_SLOT1 = 2'd1;
  localparam logic [1:0] PH_GIGA0 = 2'd2;
  localparam logic [1:0] PH_GIGA1 = 2'd3;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_VIDEO = 2'd1,
    REQ_DMA   = 2'd2,
    REQ_AUDIO = 2'd3
  } req_id_t;

endpackage

// File: rtl/xram_slot_arbiter_if.sv
// Requester / SRAM-slot bundle between the three requesters, the pin logic and the arbiter.
interface xram_slot_arbiter_if;

  logic                         SYNC;
  logic                         VREQ;
  logic [xram_pkg::XRAM_AW-1:0] VADDR;
  logic                         DREQ;
  logic                         DWE;
  logic [xram_pkg::XRAM_AW-1:0] DADDR;
  logic [xram_pkg::XRAM_DW-1:0] DWDATA;
  logic                         AREQ;
  logic [xram_pkg::XRAM_AW-1:0] AADDR;
  logic [xram_pkg::XRAM_DW-1:0] RD_IN;

  logic                         SLOT_ACT;
  logic [xram_pkg::XRAM_AW-1:0] SLOT_ADDR;
  logic                         SLOT_WE;
  logic [xram_pkg::XRAM_DW-1:0] SLOT_WDATA;
  logic                         VGNT;
  logic                         DGNT;
  logic                         AGNT;
  logic [xram_pkg::XRAM_DW-1:0] RDATA;
  logic                         VVALID;
  logic                         DVALID;
  logic                         AVALID;

  modport master (
    output SYNC, VREQ, VADDR, DREQ, DWE, DADDR, DWDATA, AREQ, AADDR, RD_IN,
    input  SLOT_ACT, SLOT_ADDR, SLOT_WE, SLOT_WDATA, VGNT, DGNT, AGNT,
           RDATA, VVALID, DVALID, AVALID
  );

  modport slave (
    input  SYNC, VREQ, VADDR, DREQ, DWE, DADDR, DWDATA, AREQ, AADDR, RD_IN,
    output SLOT_ACT, SLOT_ADDR, SLOT_WE, SLOT_WDATA, VGNT, DGNT, AGNT,
           RDATA, VVALID, DVALID, AVALID
  );

endinterface

// File: rtl/xram_slot_arbiter_rr_arb2.sv
// Two-way round-robin between DMA and audio; last_audio_reg remembers which one won last.
module rr_arb2 (
  input  logic clk,
  input  logic srst,
  input  logic dreq,
  input  logic areq,
  input  logic update,
  output logic dgnt,
  output logic agnt
);

  logic last_audio_reg;

  always_comb begin
    dgnt = dreq && (!areq || last_audio_reg);
    agnt = areq && (!dreq || !last_audio_reg);
  end

  // Reset to "audio won last" so the DMA gets the first contested slot.
  always_ff @(posedge clk) begin
    if (srst) begin
      last_audio_reg <= 1'b1;
    end else if (update && (dgnt || agnt)) begin
      last_audio_reg <= agnt;
    end
  end

endmodule

// File: rtl/xram_slot_arbiter.sv
// Aux SRAM slot arbiter: video > round-robin(DMA, audio) in phases 0/1 of each Gigatron cycle.
// DMA writes are honoured only when XRAM_DMA_WRITE_EN is defined.
module xram_slot_arbiter
  import xram_pkg::*;
(
  input  logic              CLKx4,
  input  logic              RST,
  xram_slot_arbiter_if.slave bus
);

  logic [1:0]         ph_reg;
  logic [1:0]         ph_next;
  logic               arb_edge;
  req_id_t            owner_reg;
  req_id_t            winner;
  logic               owner_we_reg;
  logic               dma_we;
  logic               rr_dgnt;
  logic               rr_agnt;
  logic [XRAM_AW-1:0] slot_addr_reg;
  logic [XRAM_DW-1:0] slot_wdata_reg;
  logic [XRAM_DW-1:0] slot_wdata_next;
  logic [XRAM_DW-1:0] rdata_reg;
  logic [2:0]         gnt;
  logic [2:0]         valid_reg;

  assign ph_next  = bus.SYNC ? PH_SLOT0 : ph_reg + 2'd1;
  assign arb_edge = !(ph_next == PH_GIGA0 || ph_next == PH_GIGA1);

`ifdef XRAM_DMA_WRITE_EN
  assign dma_we          = bus.DWE;
  assign slot_wdata_next = (winner == REQ_DMA) ? bus.DWDATA : '0;
`else
  logic unused_dma_write;
  assign unused_dma_write = bus.DWE ^ (^bus.DWDATA);
  assign dma_we           = 1'b0;
  assign slot_wdata_next  = '0;
`endif

  rr_arb2 u_rr (
    .clk    (CLKx4),
    .srst   (RST),
    .dreq   (bus.DREQ),
    .areq   (bus.AREQ),
    .update (arb_edge && !bus.VREQ),
    .dgnt   (rr_dgnt),
    .agnt   (rr_agnt)
  );

  always_comb begin
    winner = REQ_NONE;
    if (arb_edge) begin
      if (bus.VREQ) begin
        winner = REQ_VIDEO;
      end else if (rr_dgnt) begin
        winner = REQ_DMA;
      end else if (rr_agnt) begin
        winner = REQ_AUDIO;
      end
    end
  end

  // owner_reg is the slot in flight; its completion is handled on the following edge.
  always_ff @(posedge CLKx4) begin
    if (RST) begin
      ph_reg         <= PH_GIGA0;
      owner_reg      <= REQ_NONE;
      owner_we_reg   <= 1'b0;
      slot_addr_reg  <= '0;
      slot_wdata_reg <= '0;
      rdata_reg      <= '0;
    end else begin
      ph_reg         <= ph_next;
      owner_reg      <= winner;
      owner_we_reg   <= (winner == REQ_DMA) && dma_we;
      slot_wdata_reg <= slot_wdata_next;
      if (owner_reg != REQ_NONE && !owner_we_reg) begin
        rdata_reg <= bus.RD_IN;
      end
      case (winner)
        REQ_VIDEO: slot_addr_reg <= bus.VADDR;
        REQ_DMA:   slot_addr_reg <= bus.DADDR;
        REQ_AUDIO: slot_addr_reg <= bus.AADDR;
        default:   slot_addr_reg <= slot_addr_reg;
      endcase
    end
  end

  // Bit 0 = video, 1 = DMA, 2 = audio, matching the enum values 1..3.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_req
      localparam req_id_t ID = req_id_t'(2'(gi + 1));
      assign gnt[gi] = (owner_reg == ID);
      always_ff @(posedge CLKx4) begin
        if (RST) begin
          valid_reg[gi] <= 1'b0;
        end else begin
          valid_reg[gi] <= (owner_reg == ID);
        end
      end
    end
  endgenerate

  assign bus.SLOT_ACT   = (owner_reg != REQ_NONE);
  assign bus.SLOT_WE    = owner_we_reg;
  assign bus.SLOT_ADDR  = slot_addr_reg;
  assign bus.SLOT_WDATA = slot_wdata_reg;
  assign bus.VGNT       = gnt[0];
  assign bus.DGNT       = gnt[1];
  assign bus.AGNT       = gnt[2];
  assign bus.RDATA      = rdata_reg;
  assign bus.VVALID     = valid_reg[0];
  assign bus.DVALID     = valid_reg[1];
  assign bus.AVALID     = valid_reg[2];

endmodule

// File: tb/tb_xram_slot_arbiter.sv
// Scoreboard bench: a phase/round-robin reference model queues expected grants and completions.
module tb_xram_slot_arbiter;
  import xram_pkg::*;

`ifdef XRAM_DMA_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  typedef struct {
    bit          rst, sync, vreq, dreq, dwe, areq;
    logic [18:0] vaddr, daddr, aaddr;
    logic [7:0]  dwdata, rd;
  } stim_t;

  typedef struct {
    int          tag;
    int          id;
    logic [18:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } gexp_t;

  typedef struct {
    int         tag;
    int         id;
    logic [7:0] rdata;
  } vexp_t;

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  xram_slot_arbiter_if bus ();

  xram_slot_arbiter dut (
    .CLKx4 (clk),
    .RST   (rst),
    .bus   (bus)
  );

  gexp_t gq[$];
  vexp_t vq[$];
  int    total     = 0;
  int    bad       = 0;
  int    edge_cnt  = 0;
  int    reset_tag = -1;
  bit    mon_en    = 1'b0;

  // Reference model state: ids 0 none, 1 video, 2 DMA, 3 audio.
  int         m_ph;
  int         m_last;
  int         m_owner;
  bit         m_owner_we;
  logic [7:0] m_rdata;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [2:0] onehot(input int id);
    case (id)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // Drive inputs for the next edge and advance the model to that edge.
  task automatic step(input stim_t s);
    int          tag;
    logic [18:0] a;
    @(posedge clk);
    #1;
    rst        = s.rst;
    bus.SYNC   = s.sync;
    bus.VREQ   = s.vreq;
    bus.VADDR  = s.vaddr;
    bus.DREQ   = s.dreq;
    bus.DWE    = s.dwe;
    bus.DADDR  = s.daddr;
    bus.DWDATA = s.dwdata;
    bus.AREQ   = s.areq;
    bus.AADDR  = s.aaddr;
    bus.RD_IN  = s.rd;
    tag = edge_cnt + 1;
    if (s.rst) begin
      m_ph = 2; m_last = 3; m_owner = 0; m_owner_we = 0; m_rdata = 8'h00;
      reset_tag = tag;
    end else begin
      if (m_owner != 0) begin
        if (!m_owner_we) m_rdata = s.rd;
        vq.push_back('{tag, m_owner, m_rdata});
      end
      m_ph       = s.sync ? 0 : (m_ph + 1) % 4;
      m_owner    = 0;
      m_owner_we = 0;
      if (m_ph < 2) begin
        if (s.vreq)                m_owner = 1;
        else if (s.dreq && s.areq) m_owner = (m_last == 2) ? 3 : 2;
        else if (s.dreq)           m_owner = 2;
        else if (s.areq)           m_owner = 3;
        if (m_owner >= 2) m_last = m_owner;
        if (m_owner != 0) begin
          a = (m_owner == 1) ? s.vaddr : (m_owner == 2) ? s.daddr : s.aaddr;
          m_owner_we = (m_owner == 2) && s.dwe && WR_EN;
          gq.push_back('{tag, m_owner, a, m_owner_we,
                         (m_owner == 2 && WR_EN) ? s.dwdata : 8'h00});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    gexp_t      g;
    vexp_t      v;
    logic [2:0] gv;
    logic [2:0] vv;
    if (mon_en) begin
      gv = {bus.VGNT, bus.DGNT, bus.AGNT};
      vv = {bus.VVALID, bus.DVALID, bus.AVALID};
      if (edge_cnt == reset_tag) begin
        check("reset_outputs",
              {21'd0, bus.SLOT_ACT, bus.SLOT_WE, bus.SLOT_ADDR, bus.SLOT_WDATA, gv, bus.RDATA, vv},
              64'd0);
      end
      while (gq.size() > 0 && gq[0].tag < edge_cnt) begin
        g = gq.pop_front();
        check("missing_grant_at_edge", 64'(edge_cnt), 64'(g.tag));
      end
      while (vq.size() > 0 && vq[0].tag < edge_cnt) begin
        v = vq.pop_front();
        check("missing_valid_at_edge", 64'(edge_cnt), 64'(v.tag));
      end
      if (bus.SLOT_ACT || (|gv)) begin
        if (gq.size() == 0) begin
          check("unexpected_grant", {60'd0, bus.SLOT_ACT, gv}, 64'd0);
        end else begin
          g = gq.pop_front();
          check("grant_edge", 64'(edge_cnt), 64'(g.tag));
          check("grant_owner", {60'd0, bus.SLOT_ACT, gv}, {60'd0, 1'b1, onehot(g.id)});
          check("slot_addr", 64'(bus.SLOT_ADDR), 64'(g.addr));
          check("slot_we", 64'(bus.SLOT_WE), 64'(g.we));
          check("slot_wdata", 64'(bus.SLOT_WDATA), 64'(g.wdata));
        end
      end else begin
        check("idle_slot_we", 64'(bus.SLOT_WE), 64'd0);
      end
      if (|vv) begin
        if (vq.size() == 0) begin
          check("unexpected_valid", {61'd0, vv}, 64'd0);
        end else begin
          v = vq.pop_front();
          check("valid_edge", 64'(edge_cnt), 64'(v.tag));
          check("valid_owner", {61'd0, vv}, {61'd0, onehot(v.id)});
          check("rdata", 64'(bus.RDATA), 64'(v.rdata));
          $display("txn edge=%0d owner=%0d rdata=%02h", edge_cnt, v.id, bus.RDATA);
        end
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    bus.SYNC = 0; bus.VREQ = 0; bus.VADDR = '0; bus.DREQ = 0; bus.DWE = 0;
    bus.DADDR = '0; bus.DWDATA = '0; bus.AREQ = 0; bus.AADDR = '0; bus.RD_IN = '0;

    s = idle(); s.rst = 1;
    step(s);
    step(s);
    mon_en = 1'b1;

    // DMA read in phase 0, data 0xA5 captured at the end of the slot.
    s = idle(); s.sync = 1; s.dreq = 1; s.daddr = 19'h12345;
    step(s);
    s = idle(); s.rd = 8'hA5;
    step(s);
    for (int i = 0; i < 3; i++) step(idle());

    // All three requesting for four Gigatron cycles: video takes every slot.
    for (int i = 0; i < 16; i++) begin
      s = idle(); s.sync = (i == 0); s.vreq = 1; s.dreq = 1; s.areq = 1; s.dwe = 1;
      s.vaddr = 19'($urandom); s.daddr = 19'($urandom); s.aaddr = 19'($urandom);
      s.dwdata = 8'($urandom); s.rd = 8'($urandom);
      step(s);
    end

    // Fresh reset, then DMA and audio held: alternation starting with DMA.
    s = idle(); s.rst = 1;
    step(s);
    for (int i = 0; i < 16; i++) begin
      s = idle(); s.dreq = 1; s.areq = 1;
      s.daddr = 19'($urandom); s.aaddr = 19'($urandom); s.rd = 8'($urandom);
      step(s);
    end

    // DMA write at the top address.
    s = idle(); s.sync = 1; s.dreq = 1; s.dwe = 1; s.daddr = 19'h7FFFF; s.dwdata = 8'h3C;
    step(s);
    s = idle(); s.rd = 8'h5A;
    step(s);
    step(idle());

    // SYNC arriving in phase 1 while an audio read is in flight.
    s = idle(); s.sync = 1; s.areq = 1; s.aaddr = 19'h00ABC;
    step(s);
    s.sync = 0; s.aaddr = 19'h00ABD; s.rd = 8'h11;
    step(s);
    s = idle(); s.sync = 1; s.dreq = 1; s.daddr = 19'h40001; s.rd = 8'h77;
    step(s);
    s = idle(); s.rd = 8'h88;
    step(s);

    // Reset landing in a granted video slot: no completion for it.
    s = idle(); s.sync = 1; s.vreq = 1; s.vaddr = 19'h2AAAA;
    step(s);
    s = idle(); s.rst = 1; s.rd = 8'hEE;
    step(s);
    for (int i = 0; i < 4; i++) step(idle());

    // Randomised traffic including stray SYNC and reset.
    for (int i = 0; i < 3000; i++) begin
      s.rst    = ($urandom_range(0, 99) == 0);
      s.sync   = ($urandom_range(0, 15) == 0);
      s.vreq   = ($urandom_range(0, 3) == 0);
      s.dreq   = ($urandom_range(0, 1) == 1);
      s.dwe    = ($urandom_range(0, 1) == 1);
      s.areq   = ($urandom_range(0, 1) == 1);
      s.vaddr  = 19'($urandom);
      s.daddr  = 19'($urandom);
      s.aaddr  = 19'($urandom);
      s.dwdata = 8'($urandom);
      s.rd     = 8'($urandom);
      step(s);
    end

    for (int i = 0; i < 4; i++) step(idle());
    @(posedge clk);
    @(negedge clk);
    check("grant_queue_drained", 64'(gq.size()), 64'd0);
    check("valid_queue_drained", 64'(vq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
